tl_clint_device: RTL and testbench

TL_CLINT_DEVICE -- requirements
Module: tl_clint_device

---
 rtl/tl_clint_device_pkg.sv | 30 +++
 rtl/tl_clint_device.sv | 146 ++++++++++++++
 tb/tb_tl_clint_device.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tl_clint_device_pkg.sv
// Shared constants for the TileLink CLINT slave: register offsets, TL opcodes
// and the byte-lane merge used by every writable register.
package tl_clint_device_pkg;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  mask);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*8 +: 8] = mask[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_clint_device.sv
// TileLink-UL CLINT slave: msip, mtimecmp and a free-running mtime, one
// outstanding request, single-cycle response latency.
module tl_clint_device
  import tl_clint_device_pkg::*;
#(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 4,
  parameter int SinkWidth   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [2:0]             a_opcode_i,
  input  logic [2:0]             a_param_i,
  input  logic [1:0]             a_size_i,
  input  logic [SourceWidth-1:0] a_source_i,
  input  logic [AddrWidth-1:0]   a_address_i,
  input  logic [7:0]             a_mask_i,
  input  logic                   a_corrupt_i,
  input  logic [63:0]            a_data_i,
  output logic                   d_valid_o,
  input  logic                   d_ready_i,
  output logic [2:0]             d_opcode_o,
  output logic [1:0]             d_param_o,
  output logic [1:0]             d_size_o,
  output logic [SourceWidth-1:0] d_source_o,
  output logic [SinkWidth-1:0]   d_sink_o,
  output logic                   d_denied_o,
  output logic                   d_corrupt_o,
  output logic [63:0]            d_data_o,
  output logic                   irq_software_m_o,
  output logic                   irq_timer_m_o
);

  if (DataWidth != 64) begin : g_bad_data_width
    $error("tl_clint_device supports only DataWidth = 64");
  end

  logic [63:0]            mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic                   msip_q, msip_d, irq_timer_q, irq_timer_d;
  logic                   d_valid_q, d_valid_d;
  tl_d_op_e               d_opcode_q, d_opcode_d;
  logic [1:0]             d_size_q, d_size_d;
  logic [SourceWidth-1:0] d_source_q, d_source_d;
  logic                   d_denied_q, d_denied_d;
  logic [63:0]            d_data_q, d_data_d;

  logic [15:0] offset;
  logic        hit_msip, hit_cmp, hit_mtime, op_get, op_put, denied;
  logic        a_fire, d_fire;
  logic [63:0] rdata, mtime_inc;

  // Address bits above the 64 KiB window and the byte offset are not decoded.
  logic unused_inputs;
  assign unused_inputs = ^{a_param_i, a_corrupt_i, a_address_i[AddrWidth-1:16],
                           a_address_i[2:0]};

  always_comb begin
    offset    = {a_address_i[15:3], 3'b000};
    hit_msip  = (offset == OFF_MSIP);
    hit_cmp   = (offset == OFF_MTIMECMP);
    hit_mtime = (offset == OFF_MTIME);
    op_get    = (a_opcode_i == TL_GET);
    op_put    = (a_opcode_i == TL_PUT_FULL) || (a_opcode_i == TL_PUT_PARTIAL);
    denied    = !(op_get || op_put) || !(hit_msip || hit_cmp || hit_mtime);
    a_fire    = a_valid_i && !d_valid_q;
    d_fire    = d_valid_q && d_ready_i;

    rdata = '0;
    if (hit_msip)  rdata = {63'd0, msip_q};
    if (hit_cmp)   rdata = mtimecmp_q;
    if (hit_mtime) rdata = mtime_q;

    // A write to mtime overrides only the bytes it touches; others still tick.
    mtime_inc  = tick_i ? mtime_q + 64'd1 : mtime_q;
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (a_fire && op_put && !denied) begin
      if (hit_mtime) mtime_d = merge_bytes(mtime_inc, a_data_i, a_mask_i);
      if (hit_cmp)   mtimecmp_d = merge_bytes(mtimecmp_q, a_data_i, a_mask_i);
      if (hit_msip && a_mask_i[0]) msip_d = a_data_i[0];
    end

    irq_timer_d = (mtime_q >= mtimecmp_q);

    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_denied_d = d_denied_q;
    d_data_d   = d_data_q;
    if (a_fire) begin
      d_valid_d  = 1'b1;
      d_opcode_d = op_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      d_size_d   = a_size_i;
      d_source_d = a_source_i;
      d_denied_d = denied;
      d_data_d   = (op_get && !denied) ? rdata : 64'd0;
    end else if (d_fire) begin
      d_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      irq_timer_q <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      irq_timer_q <= irq_timer_d;
      d_valid_q   <= d_valid_d;
    end
  end

  // Response payload is only meaningful while d_valid_q is set.
  always_ff @(posedge clk_i) begin
    d_opcode_q <= d_opcode_d;
    d_size_q   <= d_size_d;
    d_source_q <= d_source_d;
    d_denied_q <= d_denied_d;
    d_data_q   <= d_data_d;
  end

  assign a_ready_o        = !d_valid_q;
  assign d_valid_o        = d_valid_q;
  assign d_opcode_o       = d_opcode_q;
  assign d_param_o        = 2'd0;
  assign d_size_o         = d_size_q;
  assign d_source_o       = d_source_q;
  assign d_sink_o         = '0;
  assign d_denied_o       = d_denied_q;
  assign d_corrupt_o      = d_denied_q && (d_opcode_q == TL_ACCESS_ACK_DATA);
  assign d_data_o         = d_data_q;
  assign irq_software_m_o = msip_q;
  assign irq_timer_m_o    = irq_timer_q;

endmodule

// File: tb/tb_tl_clint_device.sv
// Directed bench for tl_clint_device: hand-computed register, response and
// interrupt values for each TileLink access sequence.
module tb_tl_clint_device;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tick_i;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i;
  logic [2:0]  a_param_i;
  logic [1:0]  a_size_i;
  logic [3:0]  a_source_i;
  logic [55:0] a_address_i;
  logic [7:0]  a_mask_i;
  logic        a_corrupt_i;
  logic [63:0] a_data_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_param_o;
  logic [1:0]  d_size_o;
  logic [3:0]  d_source_o;
  logic [0:0]  d_sink_o;
  logic        d_denied_o;
  logic        d_corrupt_o;
  logic [63:0] d_data_o;
  logic        irq_software_m_o;
  logic        irq_timer_m_o;

  tl_clint_device dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
    .a_param_i(a_param_i), .a_size_i(a_size_i), .a_source_i(a_source_i),
    .a_address_i(a_address_i), .a_mask_i(a_mask_i), .a_corrupt_i(a_corrupt_i),
    .a_data_i(a_data_i), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
    .d_opcode_o(d_opcode_o), .d_param_o(d_param_o), .d_size_o(d_size_o),
    .d_source_o(d_source_o), .d_sink_o(d_sink_o), .d_denied_o(d_denied_o),
    .d_corrupt_o(d_corrupt_o), .d_data_o(d_data_o),
    .irq_software_m_o(irq_software_m_o), .irq_timer_m_o(irq_timer_m_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [2:0] PUTF = 3'd0, PUTP = 3'd1, GET = 3'd4, BADOP = 3'd2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0]  r_op;
  logic [63:0] r_data;
  logic        r_den, r_cor;
  logic [3:0]  r_src;
  logic [1:0]  r_size;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the D channel idle and d_ready_i=1.
  task automatic tl_xact(input logic [2:0] op, input logic [15:0] off, input logic [7:0] mask,
                         input logic [63:0] data, input logic [3:0] src, input logic tick);
    a_valid_i   = 1'b1;
    a_opcode_i  = op;
    a_address_i = {40'hA5_1234_5678, off};
    a_mask_i    = mask;
    a_data_i    = data;
    a_source_i  = src;
    a_size_i    = 2'd3;
    tick_i      = tick;
    @(posedge clk_i); #1;
    a_valid_i = 1'b0;
    tick_i    = 1'b0;
    check_vec("d_valid latency", d_valid_o, 1'b1);
    r_op   = d_opcode_o;
    r_data = d_data_o;
    r_den  = d_denied_o;
    r_cor  = d_corrupt_o;
    r_src  = d_source_o;
    r_size = d_size_o;
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; tick_i = 1'b0; a_valid_i = 1'b0; a_opcode_i = 3'd0; a_param_i = 3'd0;
    a_size_i = 2'd3; a_source_i = 4'd0; a_address_i = '0; a_mask_i = 8'h00;
    a_corrupt_i = 1'b0; a_data_i = 64'd0; d_ready_i = 1'b1;
    #12;
    check_vec("rst d_valid", d_valid_o, 1'b0);
    check_vec("rst irq_timer", irq_timer_m_o, 1'b0);
    check_vec("rst irq_sw", irq_software_m_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_vec("rst a_ready", a_ready_o, 1'b1);

    // mtime counts exactly the ticked cycles before the Get fires
    tick_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    tl_xact(GET, 16'hBFF8, 8'hFF, 64'd0, 4'd3, 1'b1);
    check_vec("get mtime opcode", r_op, 3'd1);
    check_vec("get mtime data", r_data, 64'd10);
    check_vec("get mtime denied", r_den, 1'b0);
    check_vec("get mtime corrupt", r_cor, 1'b0);
    check_vec("get mtime source", r_src, 4'd3);
    check_vec("get mtime size", r_size, 2'd3);
    tl_xact(GET, 16'h4000, 8'hFF, 64'd0, 4'd1, 1'b0);
    check_vec("rst mtimecmp", r_data, ONES);

    // timer interrupt rises one cycle after mtime reaches mtimecmp
    tl_xact(PUTF, 16'hBFF8, 8'hFF, 64'd0, 4'd2, 1'b0);
    tl_xact(PUTF, 16'h4000, 8'hFF, 64'd5, 4'd2, 1'b0);
    check_vec("put ack opcode", r_op, 3'd0);
    check_vec("put ack denied", r_den, 1'b0);
    check_vec("irq_timer before", irq_timer_m_o, 1'b0);
    tick_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check_vec("irq_timer at mtime=5", irq_timer_m_o, 1'b0);
    @(posedge clk_i); #1;
    check_vec("irq_timer rise", irq_timer_m_o, 1'b1);
    tick_i = 1'b0;
    tl_xact(PUTF, 16'h4000, 8'hFF, ONES, 4'd2, 1'b0);
    check_vec("irq_timer fall", irq_timer_m_o, 1'b0);

    // msip: masked lane, bit 0 only, clear
    tl_xact(PUTP, 16'h0000, 8'h00, 64'd1, 4'd4, 1'b0);
    check_vec("msip mask0", irq_software_m_o, 1'b0);
    tl_xact(PUTP, 16'h0000, 8'h01, 64'd3, 4'd4, 1'b0);
    check_vec("msip set", irq_software_m_o, 1'b1);
    tl_xact(GET, 16'h0000, 8'hFF, 64'd0, 4'd4, 1'b0);
    check_vec("msip read", r_data, 64'd1);
    tl_xact(PUTF, 16'h0000, 8'hFF, 64'd0, 4'd4, 1'b0);
    check_vec("msip clear", irq_software_m_o, 1'b0);

    // partial write to mtimecmp through an unaligned address
    tl_xact(PUTP, 16'h4004, 8'h0F, 64'h1122_3344_5566_7788, 4'd6, 1'b0);
    tl_xact(GET, 16'h4000, 8'hFF, 64'd0, 4'd6, 1'b0);
    check_vec("mtimecmp partial", r_data, 64'hFFFF_FFFF_5566_7788);
    tl_xact(PUTF, 16'h4000, 8'hFF, ONES, 4'd6, 1'b0);

    // denied accesses leave state untouched
    tl_xact(GET, 16'h1000, 8'hFF, 64'd0, 4'd8, 1'b0);
    check_vec("unmapped opcode", r_op, 3'd1);
    check_vec("unmapped denied", r_den, 1'b1);
    check_vec("unmapped corrupt", r_cor, 1'b1);
    check_vec("unmapped data", r_data, 64'd0);
    tl_xact(BADOP, 16'h4000, 8'hFF, 64'd0, 4'd8, 1'b0);
    check_vec("badop denied", r_den, 1'b1);
    check_vec("badop corrupt", r_cor, 1'b0);
    tl_xact(BADOP, 16'hBFF8, 8'hFF, 64'd0, 4'd8, 1'b0);
    tl_xact(GET, 16'h4000, 8'hFF, 64'd0, 4'd8, 1'b0);
    check_vec("badop mtimecmp kept", r_data, ONES);
    tl_xact(GET, 16'hBFF8, 8'hFF, 64'd0, 4'd8, 1'b0);
    check_vec("badop mtime kept", r_data, 64'd6);

    // backpressure: D held stable, second A waits until the cycle after D fires
    tl_xact(PUTF, 16'h0000, 8'hFF, 64'd1, 4'd5, 1'b0);
    d_ready_i = 1'b0;
    a_valid_i = 1'b1; a_opcode_i = GET; a_address_i = 56'd0; a_source_i = 4'd5;
    @(posedge clk_i); #1;
    a_opcode_i = GET; a_address_i = 56'h4000; a_source_i = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check_vec("stall d_valid", d_valid_o, 1'b1);
      check_vec("stall a_ready", a_ready_o, 1'b0);
      check_vec("stall source", d_source_o, 4'd5);
      check_vec("stall data", d_data_o, 64'd1);
    end
    d_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check_vec("release d_valid", d_valid_o, 1'b0);
    check_vec("release a_ready", a_ready_o, 1'b1);
    @(posedge clk_i); #1;
    a_valid_i = 1'b0;
    check_vec("next d_valid", d_valid_o, 1'b1);
    check_vec("next source", d_source_o, 4'd9);
    check_vec("next data", d_data_o, ONES);
    @(posedge clk_i); #1;

    // mtime wrap, and write priority over the increment
    tl_xact(PUTF, 16'hBFF8, 8'hFF, ONES, 4'd1, 1'b0);
    tick_i = 1'b1;
    @(posedge clk_i); #1;
    tick_i = 1'b0;
    tl_xact(GET, 16'hBFF8, 8'hFF, 64'd0, 4'd1, 1'b0);
    check_vec("mtime wrap", r_data, 64'd0);
    tl_xact(PUTF, 16'hBFF8, 8'hFF, 64'd100, 4'd1, 1'b1);
    tl_xact(GET, 16'hBFF8, 8'hFF, 64'd0, 4'd1, 1'b0);
    check_vec("mtime write vs tick", r_data, 64'd100);
    tl_xact(PUTF, 16'hBFF8, 8'hFF, 64'hFF, 4'd1, 1'b0);
    tl_xact(PUTP, 16'hBFF8, 8'h01, 64'h11, 4'd1, 1'b1);
    tl_xact(GET, 16'hBFF8, 8'hFF, 64'd0, 4'd1, 1'b0);
    check_vec("mtime partial vs tick", r_data, 64'h111);

    // reset during an outstanding response
    tl_xact(PUTF, 16'h4000, 8'hFF, 64'd0, 4'd2, 1'b0);
    check_vec("irq_timer cmp=0", irq_timer_m_o, 1'b1);
    d_ready_i = 1'b0;
    a_valid_i = 1'b1; a_opcode_i = GET; a_address_i = 56'hBFF8; a_source_i = 4'd7;
    @(posedge clk_i); #1;
    a_valid_i = 1'b0;
    check_vec("pending d_valid", d_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check_vec("midrst d_valid", d_valid_o, 1'b0);
    check_vec("midrst a_ready", a_ready_o, 1'b1);
    check_vec("midrst irq_timer", irq_timer_m_o, 1'b0);
    check_vec("midrst irq_sw", irq_software_m_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    d_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check_vec("postrst d_valid", d_valid_o, 1'b0);
    tl_xact(GET, 16'h4000, 8'hFF, 64'd0, 4'd2, 1'b0);
    check_vec("postrst mtimecmp", r_data, ONES);
    tl_xact(GET, 16'hBFF8, 8'hFF, 64'd0, 4'd2, 1'b0);
    check_vec("postrst mtime", r_data, 64'd0);
    tl_xact(GET, 16'h0000, 8'hFF, 64'd0, 4'd2, 1'b0);
    check_vec("postrst msip", r_data, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
